// File: rtl/gate_response_checker.sv
`default_nettype none
// ============================================================================
// Module   : gate_response_checker
// Brief    : Scores (a, b, y) samples from a two-input gate against the
//            selected operation, counting passes/fails and input coverage.
// Revision : 1.0 - initial release
// ============================================================================
module gate_response_checker #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic             in_valid,
   input  logic             a,
   input  logic             b,
   input  logic             y,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt,
   output logic [3:0]       cov,
   output logic             ff_a,
   output logic             ff_b,
   output logic             ff_y,
   output logic [CNT_W-1:0] ff_idx
);

   localparam logic [CNT_W-1:0] c_cnt_max = '1;
   localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [1:0]       r_op;
   logic [CNT_W-1:0] r_idx;
   logic             w_exp;
   logic             w_match;
   logic [1:0]       w_combo;

   always_comb begin
      w_exp = 1'b0;
      case (r_op)
         2'd0:    w_exp = a & b;
         2'd1:    w_exp = a | b;
         2'd2:    w_exp = a ^ b;
         default: w_exp = ~(a & b);
      endcase
   end

   assign w_match = (y == w_exp);
   assign w_combo = {a, b};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_op     <= 2'd0;
         r_idx    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         pass_cnt <= '0;
         fail_cnt <= '0;
         cov      <= 4'h0;
         ff_a     <= 1'b0;
         ff_b     <= 1'b0;
         ff_y     <= 1'b0;
         ff_idx   <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_state  <= S_RUN;
                  r_op     <= op;
                  r_idx    <= '0;
                  busy     <= 1'b1;
                  done     <= 1'b0;
                  err      <= 1'b0;
                  pass_cnt <= '0;
                  fail_cnt <= '0;
                  cov      <= 4'h0;
                  ff_a     <= 1'b0;
                  ff_b     <= 1'b0;
                  ff_y     <= 1'b0;
                  ff_idx   <= '0;
               end
            end
            S_RUN: begin
               if (in_valid) begin
                  if (w_match) begin
                     if (pass_cnt != c_cnt_max) pass_cnt <= pass_cnt + c_cnt_one;
                  end else begin
                     if (fail_cnt != c_cnt_max) fail_cnt <= fail_cnt + c_cnt_one;
                  end
                  cov <= cov | (4'b0001 << w_combo);
                  if (r_idx != c_cnt_max) r_idx <= r_idx + c_cnt_one;
                  // Only the first mismatch of a run is captured; err gates the rest.
                  if (!w_match && !err) begin
                     err    <= 1'b1;
                     ff_a   <= a;
                     ff_b   <= b;
                     ff_y   <= y;
                     ff_idx <= r_idx;
                  end
               end
               // Exit looks at the registered bitmap, so one extra sample can land.
               if (cov == 4'hF) begin
                  r_state <= S_DONE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
